// File: rtl/kraaken_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : kraaken_stream_feeder
//  Description : Sequences the shared regex finger control bus for a tagged
//                byte stream and returns one fired-flag result per packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module kraaken_stream_feeder #(
    parameter int NUM_REGEX = 8,
    parameter int EOP_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_vld,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [5:0]           in_stream_id,
    output logic                 in_rdy,
    input  logic                 cfg_we,
    input  logic                 cfg_clr,
    input  logic [5:0]           cfg_addr,
    input  logic [NUM_REGEX-1:0] cfg_en_mask,
    output logic                 load_state,
    output logic [5:0]           stream_id,
    output logic                 new_stream_id,
    output logic [NUM_REGEX-1:0] enable,
    output logic [7:0]           char_out,
    output logic                 char_out_vld,
    output logic                 eop,
    input  logic [NUM_REGEX-1:0] fired_in,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [5:0]           res_stream_id,
    output logic [NUM_REGEX-1:0] res_fired,
    output logic [15:0]          drop_cnt
);

    // DRAIN spends EOP_DELAY-1 cycles; the counter runs down to zero inclusive.
    localparam logic [2:0] c_DRAIN_LOAD = (EOP_DELAY > 1) ? 3'(EOP_DELAY - 2) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_PRIME  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_EOP    = 3'd5,
        S_CAPT   = 3'd6,
        S_REPORT = 3'd7
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [5:0]             r_sid;
    logic [NUM_REGEX-1:0]   r_en;
    logic                   r_new;
    logic [63:0]            r_seen;
    logic [NUM_REGEX-1:0]   r_mask [64];
    logic [2:0]             r_dly;
    logic [7:0]             r_char;
    logic [5:0]             r_res_sid;
    logic [NUM_REGEX-1:0]   r_res_fired;
    logic [15:0]            r_drop;

    logic                   w_start;
    logic                   w_drop;

    assign w_start = (r_state == S_IDLE) && in_vld && in_sop;
    assign w_drop  = (r_state == S_IDLE) && in_vld && !in_sop;

    always_comb begin
        w_next       = r_state;
        in_rdy       = 1'b0;
        char_out_vld = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_vld) begin
                    if (in_sop) begin
                        w_next = S_LOAD;
                    end else begin
                        in_rdy = 1'b1;
                    end
                end
            end
            S_LOAD:  w_next = S_PRIME;
            S_PRIME: w_next = S_STREAM;
            S_STREAM: begin
                in_rdy       = 1'b1;
                char_out_vld = in_vld;
                if (in_vld && in_eop) begin
                    w_next = (EOP_DELAY > 1) ? S_DRAIN : S_EOP;
                end
            end
            S_DRAIN: begin
                if (r_dly == 3'd0) begin
                    w_next = S_EOP;
                end
            end
            S_EOP:  w_next = S_CAPT;
            S_CAPT: w_next = S_REPORT;
            S_REPORT: begin
                if (res_rdy) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sid       <= 6'd0;
            r_en        <= '0;
            r_new       <= 1'b0;
            r_seen      <= 64'd0;
            r_dly       <= 3'd0;
            r_char      <= 8'd0;
            r_res_sid   <= 6'd0;
            r_res_fired <= '0;
            r_drop      <= 16'd0;
            for (int i = 0; i < 64; i++) begin
                r_mask[i] <= '1;
            end
        end else begin
            r_state <= w_next;

            // Table reads below see the pre-write value on a same-cycle write.
            if (cfg_we) begin
                r_mask[cfg_addr] <= cfg_en_mask;
            end
            if (cfg_clr) begin
                r_seen[cfg_addr] <= 1'b0;
            end
            // Later assignment wins, so the LOAD seen-set beats a same-id clear.
            if (r_state == S_LOAD) begin
                r_seen[r_sid] <= 1'b1;
            end

            if (w_start) begin
                r_sid <= in_stream_id;
                r_en  <= r_mask[in_stream_id];
                r_new <= ~r_seen[in_stream_id];
            end

            if (w_drop) begin
                r_drop <= r_drop + 16'd1;
            end

            if (char_out_vld) begin
                r_char <= in_data;
            end

            if (r_state == S_STREAM) begin
                r_dly <= c_DRAIN_LOAD;
            end else if (r_state == S_DRAIN) begin
                r_dly <= r_dly - 3'd1;
            end

            if (r_state == S_CAPT) begin
                r_res_fired <= fired_in;
                r_res_sid   <= r_sid;
            end
        end
    end

    assign load_state    = (r_state == S_LOAD);
    assign new_stream_id = load_state & r_new;
    assign stream_id     = r_sid;
    assign enable        = r_en;
    assign char_out      = char_out_vld ? in_data : r_char;
    assign eop           = (r_state == S_EOP);
    assign res_vld       = (r_state == S_REPORT);
    assign res_stream_id = r_res_sid;
    assign res_fired     = r_res_fired;
    assign drop_cnt      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_kraaken_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kraaken_stream_feeder
//  Description : Directed self-checking bench for kraaken_stream_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kraaken_stream_feeder;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_sop;
    logic        in_eop;
    logic [5:0]  in_stream_id;
    logic        in_rdy;
    logic        cfg_we;
    logic        cfg_clr;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_en_mask;
    logic        load_state;
    logic [5:0]  stream_id;
    logic        new_stream_id;
    logic [7:0]  enable;
    logic [7:0]  char_out;
    logic        char_out_vld;
    logic        eop;
    logic [7:0]  fired_in;
    logic        res_vld;
    logic        res_rdy;
    logic [5:0]  res_stream_id;
    logic [7:0]  res_fired;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    kraaken_stream_feeder #(
        .NUM_REGEX (8),
        .EOP_DELAY (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_vld        (in_vld),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .in_stream_id  (in_stream_id),
        .in_rdy        (in_rdy),
        .cfg_we        (cfg_we),
        .cfg_clr       (cfg_clr),
        .cfg_addr      (cfg_addr),
        .cfg_en_mask   (cfg_en_mask),
        .load_state    (load_state),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .enable        (enable),
        .char_out      (char_out),
        .char_out_vld  (char_out_vld),
        .eop           (eop),
        .fired_in      (fired_in),
        .res_vld       (res_vld),
        .res_rdy       (res_rdy),
        .res_stream_id (res_stream_id),
        .res_fired     (res_fired),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full packet from an IDLE cycle back to the next IDLE cycle, EOP_DELAY=2.
    task automatic run_pkt(input logic [5:0] id, input int n, input logic [7:0] d0,
                           input logic exp_new, input logic [7:0] exp_en,
                           input logic [7:0] fired, input bit mid_wr, input int hold);
        in_vld       = 1'b1;
        in_sop       = 1'b1;
        in_eop       = (n == 1);
        in_data      = d0;
        in_stream_id = id;
        fired_in     = fired;
        res_rdy      = (hold == 0);
        #1;
        check("idle_sop_rdy", in_rdy, 0);
        check("idle_no_load", load_state, 0);
        cyc();
        check("load_pulse", load_state, 1);
        check("load_sid", stream_id, id);
        check("load_new", new_stream_id, exp_new);
        check("load_en", enable, exp_en);
        check("load_no_char", char_out_vld, 0);
        cyc();
        check("prime_load", load_state, 0);
        check("prime_no_char", char_out_vld, 0);
        check("prime_rdy", in_rdy, 0);
        for (int i = 0; i < n; i++) begin
            cyc();
            if (i > 0) begin
                in_sop  = 1'b0;
                in_data = 8'(d0 + 8'(i));
                in_eop  = (i == n - 1);
            end
            if (mid_wr) begin
                cfg_we      = (i == 0);
                cfg_addr    = id;
                cfg_en_mask = 8'h3C;
            end
            #1;
            check("str_vld", char_out_vld, 1);
            check("str_char", char_out, 8'(d0 + 8'(i)));
            check("str_rdy", in_rdy, 1);
            check("str_en", enable, exp_en);
            check("str_eop", eop, 0);
            check("str_load", load_state, 0);
        end
        cyc();
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        cfg_we = 1'b0;
        #1;
        check("drain_vld", char_out_vld, 0);
        check("drain_hold_char", char_out, 8'(d0 + 8'(n - 1)));
        check("drain_eop", eop, 0);
        cyc();
        check("eop_pulse", eop, 1);
        check("eop_en", enable, exp_en);
        check("eop_sid", stream_id, id);
        check("eop_no_char", char_out_vld, 0);
        cyc();
        check("capt_eop", eop, 0);
        check("capt_res", res_vld, 0);
        cyc();
        check("rep_vld", res_vld, 1);
        check("rep_sid", res_stream_id, id);
        check("rep_fired", res_fired, fired);
        check("rep_rdy", in_rdy, 0);
        fired_in = ~fired;
        for (int k = 1; k <= hold; k++) begin
            cyc();
            check("hold_vld", res_vld, 1);
            check("hold_sid", res_stream_id, id);
            check("hold_fired", res_fired, fired);
            check("hold_rdy", in_rdy, 0);
            check("hold_load", load_state, 0);
        end
        res_rdy = 1'b1;
        cyc();
        check("post_res", res_vld, 0);
        check("post_load", load_state, 0);
    endtask

    initial begin
        rst          = 1'b1;
        in_data      = 8'd0;
        in_vld       = 1'b0;
        in_sop       = 1'b0;
        in_eop       = 1'b0;
        in_stream_id = 6'd0;
        cfg_we       = 1'b0;
        cfg_clr      = 1'b0;
        cfg_addr     = 6'd0;
        cfg_en_mask  = 8'd0;
        fired_in     = 8'd0;
        res_rdy      = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("rst_load", load_state, 0);
        check("rst_en", enable, 0);
        check("rst_sid", stream_id, 0);
        check("rst_char", char_out, 0);
        check("rst_res", res_vld, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_rdy", in_rdy, 0);
        cyc();

        // T1: first packet on stream 5
        run_pkt(6'd5, 3, 8'd61, 1'b1, 8'hFF, 8'h04, 1'b0, 0);
        // T2: repeat stream, then clear seen
        run_pkt(6'd5, 2, 8'h40, 1'b0, 8'hFF, 8'h10, 1'b0, 0);
        cfg_clr  = 1'b1;
        cfg_addr = 6'd5;
        cyc();
        cfg_clr = 1'b0;
        run_pkt(6'd5, 2, 8'h50, 1'b1, 8'hFF, 8'h20, 1'b0, 0);

        // T3: mask write, then mid-packet write applies to next packet only
        cfg_we      = 1'b1;
        cfg_addr    = 6'd9;
        cfg_en_mask = 8'h81;
        cyc();
        cfg_we = 1'b0;
        run_pkt(6'd9, 3, 8'h90, 1'b1, 8'h81, 8'h81, 1'b1, 0);
        run_pkt(6'd9, 2, 8'hA0, 1'b0, 8'h3C, 8'h0C, 1'b0, 0);

        // T4: beats without sop in IDLE are dropped
        in_vld  = 1'b1;
        in_sop  = 1'b0;
        in_data = 8'hAA;
        #1;
        check("drop_rdy0", in_rdy, 1);
        cyc();
        check("drop_rdy1", in_rdy, 1);
        check("drop_cnt1", drop_cnt, 1);
        check("drop_load1", load_state, 0);
        cyc();
        in_vld = 1'b0;
        #1;
        check("drop_cnt2", drop_cnt, 2);
        check("drop_load2", load_state, 0);
        check("drop_idle_rdy", in_rdy, 0);
        cyc();

        // T5: single-beat packet with result back-pressure
        run_pkt(6'd12, 1, 8'h7E, 1'b1, 8'hFF, 8'hA5, 1'b0, 5);

        // T6: reset during STREAM
        in_vld       = 1'b1;
        in_sop       = 1'b1;
        in_eop       = 1'b0;
        in_data      = 8'h70;
        in_stream_id = 6'd5;
        cyc();
        cyc();
        cyc();
        check("t6_stream", char_out_vld, 1);
        rst = 1'b1;
        cyc();
        rst    = 1'b0;
        in_vld = 1'b0;
        in_sop = 1'b0;
        #1;
        check("t6_vld", char_out_vld, 0);
        check("t6_char", char_out, 0);
        check("t6_load", load_state, 0);
        check("t6_sid", stream_id, 0);
        check("t6_en", enable, 0);
        check("t6_drop", drop_cnt, 0);
        check("t6_rdy", in_rdy, 0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("t6_no_eop", eop, 0);
            check("t6_no_res", res_vld, 0);
        end
        run_pkt(6'd5, 2, 8'h20, 1'b1, 8'hFF, 8'h11, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
